// File: rtl/pc_unit.sv
// Program-counter stage: holds the fetch address, selects the next PC, and
// tracks run/halt state, a saturating retired-instruction count and a sticky
// misaligned-target flag.
module pc_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned      CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       pc_sel,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] offset,
    input  logic [WIDTH-1:0] jump_addr,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             halted,
    output logic             misaligned,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;
    localparam logic [1:0] SEL_HOLD   = 2'b11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_misaligned;
    logic             w_misaligned_nxt;
    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_branch_tgt;
    logic [WIDTH-1:0] w_target;
    logic             w_load_target;

    // Sequential and branch adders; wrap modulo 2^WIDTH by construction.
    assign w_pc_plus4   = r_pc + WIDTH'(4);
    assign w_branch_tgt = r_pc + offset;

    // Counter increment that sticks at all-ones instead of wrapping.
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    // State, PC, counter and sticky flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_cnt        <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_cnt        <= w_cnt_nxt;
            r_misaligned <= w_misaligned_nxt;
        end
    end

    // Next-state logic: stall > halt > pc_sel in RUN; only resume matters in HALT.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_cnt_nxt        = r_cnt;
        w_misaligned_nxt = r_misaligned;
        w_target         = '0;
        w_load_target    = 1'b0;

        unique case (r_state)
            ST_RUN: begin
                if (!stall) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (halt) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        unique case (pc_sel)
                            SEL_SEQ: w_pc_nxt = w_pc_plus4;
                            SEL_BRANCH: begin
                                if (branch_taken) begin
                                    w_target      = w_branch_tgt;
                                    w_load_target = 1'b1;
                                end else begin
                                    w_pc_nxt = w_pc_plus4;
                                end
                            end
                            SEL_JUMP: begin
                                w_target      = jump_addr;
                                w_load_target = 1'b1;
                            end
                            SEL_HOLD: w_pc_nxt = r_pc;
                            default:  w_pc_nxt = r_pc;
                        endcase
                    end
                end
            end
            ST_HALT: begin
                if (resume) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = w_pc_plus4;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase

        // Loaded targets are word-aligned; a dropped low bit latches the flag.
        if (w_load_target) begin
            w_pc_nxt = {w_target[WIDTH-1:2], 2'b00};
            if (w_target[1:0] != 2'b00) begin
                w_misaligned_nxt = 1'b1;
            end
        end
    end

    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign halted      = (r_state == ST_HALT);
    assign misaligned  = r_misaligned;
    assign instr_count = r_cnt;

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit with hand-computed expected values.
module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic [1:0]  pc_sel;
    logic        branch_taken;
    logic [31:0] offset;
    logic [31:0] jump_addr;
    logic        stall;
    logic        halt;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        misaligned;
    logic [31:0] instr_count;

    // Second instance with a narrow counter for saturation.
    logic        rst4;
    logic [31:0] pc4;
    logic [31:0] pc_plus4_4;
    logic        halted4;
    logic        misaligned4;
    logic [3:0]  instr_count4;

    int checks   = 0;
    int failures = 0;

    pc_unit #(.WIDTH(32), .RESET_PC(32'h0), .CNT_W(32)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .pc_sel      (pc_sel),
        .branch_taken(branch_taken),
        .offset      (offset),
        .jump_addr   (jump_addr),
        .stall       (stall),
        .halt        (halt),
        .resume      (resume),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .halted      (halted),
        .misaligned  (misaligned),
        .instr_count (instr_count)
    );

    pc_unit #(.WIDTH(32), .RESET_PC(32'h0), .CNT_W(4)) u_dut4 (
        .clk         (clk),
        .rst         (rst4),
        .pc_sel      (2'b00),
        .branch_taken(1'b0),
        .offset      (32'h0),
        .jump_addr   (32'h0),
        .stall       (1'b0),
        .halt        (1'b0),
        .resume      (1'b0),
        .pc          (pc4),
        .pc_plus4    (pc_plus4_4),
        .halted      (halted4),
        .misaligned  (misaligned4),
        .instr_count (instr_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs may be changed and outputs sampled 1ns after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        pc_sel       = 2'b00;
        branch_taken = 1'b0;
        offset       = 32'h0;
        jump_addr    = 32'h0;
        stall        = 1'b0;
        halt         = 1'b0;
        resume       = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        rst4 = 1'b1;
        idle_inputs();
        step(2);

        chk("reset_pc",       pc,                  32'h0);
        chk("reset_halted",   32'(halted),         32'h0);
        chk("reset_misalign", 32'(misaligned),     32'h0);
        chk("reset_count",    instr_count,         32'h0);
        rst = 1'b0;

        // Sequential fetch.
        step(1);
        chk("seq_pc1", pc, 32'h4);
        step(2);
        chk("seq_pc3",      pc,          32'hC);
        chk("seq_count3",   instr_count, 32'd3);
        chk("seq_pc_plus4", pc_plus4,    32'h10);

        // Branch taken / not taken, misaligned jump.
        pc_sel = 2'b10; jump_addr = 32'h20;
        step(1);
        chk("jump_0x20", pc, 32'h20);
        pc_sel = 2'b01; offset = 32'hFFFF_FFF8; branch_taken = 1'b1;
        step(1);
        chk("branch_taken", pc, 32'h18);
        branch_taken = 1'b0;
        step(1);
        chk("branch_not_taken", pc, 32'h1C);
        chk("aligned_no_flag", 32'(misaligned), 32'h0);
        pc_sel = 2'b10; jump_addr = 32'h102;
        step(1);
        chk("jump_misaligned_pc",   pc,              32'h100);
        chk("jump_misaligned_flag", 32'(misaligned), 32'h1);
        pc_sel = 2'b00;
        step(1);
        chk("sticky_pc",   pc,              32'h104);
        chk("sticky_flag", 32'(misaligned), 32'h1);
        chk("count_8",     instr_count,     32'd8);

        // Hold select still retires.
        pc_sel = 2'b11;
        step(1);
        chk("hold_pc",    pc,          32'h104);
        chk("hold_count", instr_count, 32'd9);

        // Stall over halt, then halt, HALT ignores select, resume.
        pc_sel = 2'b10; jump_addr = 32'h40;
        step(1);
        chk("jump_0x40", pc, 32'h40);
        stall = 1'b1; halt = 1'b1; pc_sel = 2'b00;
        step(2);
        chk("stall_pc",     pc,           32'h40);
        chk("stall_halted", 32'(halted),  32'h0);
        chk("stall_count",  instr_count,  32'd10);
        stall = 1'b0;
        step(1);
        chk("halt_halted", 32'(halted), 32'h1);
        chk("halt_pc",     pc,          32'h40);
        chk("halt_count",  instr_count, 32'd11);
        halt = 1'b0; pc_sel = 2'b10; jump_addr = 32'h80; stall = 1'b1;
        step(1);
        stall = 1'b0; halt = 1'b1;
        step(2);
        chk("in_halt_pc",     pc,          32'h40);
        chk("in_halt_count",  instr_count, 32'd11);
        chk("in_halt_halted", 32'(halted), 32'h1);
        resume = 1'b1; halt = 1'b1;
        step(1);
        chk("resume_pc",     pc,          32'h44);
        chk("resume_halted", 32'(halted), 32'h0);
        chk("resume_count",  instr_count, 32'd11);

        // Resume ignored in RUN.
        halt = 1'b0; pc_sel = 2'b00;
        step(1);
        chk("run_resume_pc",     pc,          32'h48);
        chk("run_resume_halted", 32'(halted), 32'h0);
        chk("run_resume_count",  instr_count, 32'd12);
        resume = 1'b0;

        // Wrap-around.
        pc_sel = 2'b10; jump_addr = 32'hFFFF_FFFC;
        step(1);
        chk("wrap_top_pc",    pc,       32'hFFFF_FFFC);
        chk("wrap_top_plus4", pc_plus4, 32'h0);
        pc_sel = 2'b00;
        step(1);
        chk("wrap_pc",       pc,              32'h0);
        chk("wrap_misalign", 32'(misaligned), 32'h1);

        // Negative-offset wrap from zero with a misaligned branch target.
        pc_sel = 2'b01; branch_taken = 1'b1; offset = 32'hFFFF_FFFE;
        step(1);
        chk("neg_wrap_pc", pc, 32'hFFFF_FFFC);
        branch_taken = 1'b0;

        // Async reset while halted with count 7.
        idle_inputs();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        pc_sel = 2'b10; jump_addr = 32'h2;
        step(1);
        chk("pre_rst_misalign", 32'(misaligned), 32'h1);
        pc_sel = 2'b00;
        step(5);
        halt = 1'b1;
        step(1);
        halt = 1'b0;
        chk("pre_rst_halted", 32'(halted),  32'h1);
        chk("pre_rst_count",  instr_count,  32'd7);
        chk("pre_rst_pc",     pc,           32'h14);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pc",       pc,              32'h0);
        chk("async_rst_halted",   32'(halted),     32'h0);
        chk("async_rst_count",    instr_count,     32'h0);
        chk("async_rst_misalign", 32'(misaligned), 32'h0);
        step(1);
        rst = 1'b0;

        // Counter saturation on the 4-bit instance.
        rst4 = 1'b0;
        step(14);
        chk("sat_count14", 32'(instr_count4), 32'hE);
        step(1);
        chk("sat_count15", 32'(instr_count4), 32'hF);
        step(5);
        chk("sat_count20", 32'(instr_count4), 32'hF);
        chk("sat_pc20",    pc4,               32'd80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
